// File: rtl/scroll_display.sv
// scroll_display: N-digit multiplexed seven-segment scroller (marquee mode with SCROLL_MARQUEE_EN)
module scroll_display #(
  parameter int DIGITS        = 7,
  parameter int SEG_W         = 7,
  parameter int SCAN_DIV      = 25000,
  parameter int STEP_DIV_BASE = 6250000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              dir,
  input  logic              mode,
  input  logic [1:0]        freq,
  input  logic              wr_en,
  input  logic [3:0]        wr_addr,
  input  logic [SEG_W-1:0]  wr_data,
  output logic [DIGITS-1:0] trans,
  output logic [SEG_W-1:0]  led7seg,
  output logic              step_pulse,
  output logic              wrap
);
  localparam int SCW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int TW  = $clog2(STEP_DIV_BASE * 8);
  localparam int SLW = $clog2(DIGITS);
  localparam int OW  = $clog2(2 * DIGITS);
  localparam int IW  = $clog2(3 * DIGITS);
  logic [SEG_W-1:0]  seg_buf_q [DIGITS];
  logic [SEG_W-1:0]  seg_buf_d [DIGITS];
  logic [SCW-1:0]    scan_q, scan_d;
  logic [SLW-1:0]    sel_q, sel_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [OW-1:0]     offset_q, offset_d;
  logic              step_pulse_q, step_pulse_d;
  logic              wrap_q, wrap_d;
  logic [DIGITS-1:0] trans_q, trans_d;
  logic [SEG_W-1:0]  led7seg_q, led7seg_d;
  logic              scan_term, step_due, step, marq, mode_chg, blank;
  logic [TW:0]       period;
  logic [OW-1:0]     off_max, off_nxt;
  logic [IW-1:0]     idx, wrapped;
  logic [SLW-1:0]    pos;
`ifdef SCROLL_MARQUEE_EN
  logic mode_q;
  // remember the previous mode so a change can restart the scroll cleanly
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mode_q <= 1'b0;
    else        mode_q <= mode;
  assign marq     = mode;
  assign mode_chg = mode != mode_q;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign marq        = 1'b0;
  assign mode_chg    = 1'b0;
`endif
  // buffer write port; slots at or beyond DIGITS match no entry
  always_comb
    for (int i = 0; i < DIGITS; i++)
      seg_buf_d[i] = (wr_en && 32'(wr_addr) == i) ? wr_data : seg_buf_q[i];
  // scan slot counter and digit select, parked at 0 while disabled
  always_comb begin
    scan_term = scan_q == SCW'(SCAN_DIV - 1);
    scan_d    = (!enable || scan_term) ? '0 : scan_q + SCW'(1);
    sel_d     = !enable ? '0 : !scan_term ? sel_q : (sel_q == SLW'(DIGITS - 1)) ? '0 : sel_q + SLW'(1);
  end
  // step timer and scroll offset; >= compare keeps a shortened period from stalling
  always_comb begin
    period       = (TW + 1)'(STEP_DIV_BASE) << (2'd3 - freq);
    step_due     = {1'b0, timer_q} >= period - (TW + 1)'(1);
    step         = enable && !mode_chg && step_due;
    timer_d      = (!enable || mode_chg || step_due) ? '0 : timer_q + TW'(1);
    off_max      = marq ? OW'(2 * DIGITS - 1) : OW'(DIGITS - 1);
    off_nxt      = dir ? ((offset_q == '0) ? off_max : offset_q - OW'(1))
                       : ((offset_q == off_max) ? '0 : offset_q + OW'(1));
    offset_d     = (!enable || mode_chg) ? '0 : step ? off_nxt : offset_q;
    step_pulse_d = step;
    wrap_d       = step && off_nxt == '0;
  end
  // digit/pattern pair for the current scan position, blanked while disabled
  always_comb begin
    idx = IW'(sel_q) + IW'(offset_q);
`ifdef SCROLL_MARQUEE_EN
    wrapped = (idx >= IW'(2 * DIGITS)) ? idx - IW'(2 * DIGITS) : idx;
    blank   = marq && wrapped >= IW'(DIGITS);
`else
    wrapped = idx;
    blank   = 1'b0;
`endif
    pos       = SLW'((wrapped >= IW'(DIGITS)) ? wrapped - IW'(DIGITS) : wrapped);
    trans_d   = enable ? ~({1'b1, {(DIGITS - 1){1'b0}}} >> sel_q) : '1;
    led7seg_d = (enable && !blank) ? seg_buf_q[pos] : '1;
  end
  // pattern buffer, reset to blank
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < DIGITS; i++) seg_buf_q[i] <= '1;
    else        seg_buf_q <= seg_buf_d;
  // counters, offset and registered outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      scan_q       <= '0;
      sel_q        <= '0;
      timer_q      <= '0;
      offset_q     <= '0;
      step_pulse_q <= 1'b0;
      wrap_q       <= 1'b0;
      trans_q      <= '1;
      led7seg_q    <= '1;
    end else begin
      scan_q       <= scan_d;
      sel_q        <= sel_d;
      timer_q      <= timer_d;
      offset_q     <= offset_d;
      step_pulse_q <= step_pulse_d;
      wrap_q       <= wrap_d;
      trans_q      <= trans_d;
      led7seg_q    <= led7seg_d;
    end
  assign trans      = trans_q;
  assign led7seg    = led7seg_q;
  assign step_pulse = step_pulse_q;
  assign wrap       = wrap_q;
endmodule

// File: tb/tb_scroll_display.sv
// tb_scroll_display: directed self-checking bench for scroll_display (4 digits, short dividers)
module tb_scroll_display;
  logic       clk = 1'b0, rst_n = 1'b1, enable = 1'b0, dir = 1'b0, mode = 1'b0, wr_en = 1'b0;
  logic [1:0] freq = 2'd0;
  logic [3:0] wr_addr = 4'd0;
  logic [6:0] wr_data = 7'd0;
  logic [3:0] trans;
  logic [6:0] led7seg;
  logic       step_pulse, wrap;
  int         checks = 0, failures = 0;
  logic [3:0] tr_exp [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
  logic [6:0] led_exp [4] = '{7'h01, 7'h02, 7'h04, 7'h08};

  scroll_display #(.DIGITS(4), .SEG_W(7), .SCAN_DIV(4), .STEP_DIV_BASE(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .dir(dir), .mode(mode), .freq(freq),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .trans(trans), .led7seg(led7seg), .step_pulse(step_pulse), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [6:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc(1);
    wr_en = 1'b0;
  endtask

  task automatic restart(input logic d, input logic [1:0] f);
    enable = 1'b0;
    cyc(1);
    check("idle_trans", trans, 4'hF);
    check("idle_led", led7seg, 7'h7F);
    dir = d; freq = f; enable = 1'b1;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("rst_trans", trans, 4'hF);
    check("rst_led", led7seg, 7'h7F);
    check("rst_step", step_pulse, 1'b0);
    check("rst_wrap", wrap, 1'b0);
    cyc(2);
    rst_n = 1'b1;
    wr(4'd0, 7'h01); wr(4'd1, 7'h02); wr(4'd2, 7'h04); wr(4'd3, 7'h08);
    wr(4'd4, 7'h55); wr(4'd15, 7'h66);
    freq = 2'd0; dir = 1'b0; enable = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      cyc(1);
      check("scan_trans", trans, tr_exp[(n - 1) / 4]);
      check("scan_led", led7seg, led_exp[(n - 1) / 4]);
    end
    cyc(4);
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 7'h20;
    cyc(1);
    wr_en = 1'b0;
    check("wr_same_cycle_old", led7seg, 7'h02);
    cyc(1);
    check("wr_next_new", led7seg, 7'h20);
    wr(4'd1, 7'h02);

    restart(1'b0, 2'd3);
    for (int n = 1; n <= 33; n++) begin
      cyc(1);
      check("rl_step", step_pulse, n % 8 == 0);
      check("rl_wrap", wrap, n == 32);
      if (n == 9)  begin check("rl_p2_trans", trans, 4'b1101); check("rl_p2_led", led7seg, 7'h08); end
      if (n == 13) begin check("rl_p3_trans", trans, 4'b1110); check("rl_p3_led", led7seg, 7'h01); end
      if (n == 17) begin check("rl_p0_trans", trans, 4'b0111); check("rl_p0_led", led7seg, 7'h04); end
      if (n == 33) begin check("rl_wr_trans", trans, 4'b0111); check("rl_wr_led", led7seg, 7'h01); end
    end

    restart(1'b1, 2'd0);
    cyc(63);
    check("rr_no_step", step_pulse, 1'b0);
    cyc(1);
    check("rr_step", step_pulse, 1'b1);
    check("rr_no_wrap", wrap, 1'b0);
    cyc(1);
    check("rr_p0_trans", trans, 4'b0111);
    check("rr_p0_led", led7seg, 7'h08);

    restart(1'b0, 2'd0);
    cyc(40);
    check("fq_before", step_pulse, 1'b0);
    freq = 2'd3;
    cyc(1);
    check("fq_immediate", step_pulse, 1'b1);
    cyc(7);
    check("fq_cleared", step_pulse, 1'b0);
    cyc(1);
    check("fq_next", step_pulse, 1'b1);

`ifdef SCROLL_MARQUEE_EN
    mode = 1'b1;
    restart(1'b0, 2'd2);
    cyc(48);
    check("mq_step3", step_pulse, 1'b1);
    check("mq_step3_wrap", wrap, 1'b0);
    cyc(1);
    check("mq_p0_trans", trans, 4'b0111);
    check("mq_p0_led", led7seg, 7'h08);
    cyc(4);
    check("mq_p1_trans", trans, 4'b1011);
    check("mq_p1_led", led7seg, 7'h7F);
    cyc(4);
    check("mq_p2_led", led7seg, 7'h7F);
    cyc(4);
    check("mq_p3_trans", trans, 4'b1110);
    check("mq_p3_led", led7seg, 7'h7F);
    cyc(51);
    check("mq_step7", step_pulse, 1'b1);
    check("mq_step7_wrap", wrap, 1'b0);
    cyc(16);
    check("mq_step8", step_pulse, 1'b1);
    check("mq_step8_wrap", wrap, 1'b1);
    cyc(22);
    mode = 1'b0;
    cyc(1);
    check("mc_no_step", step_pulse, 1'b0);
    cyc(9);
    check("mc_timer_cleared", step_pulse, 1'b0);
    cyc(1);
    check("mc_trans", trans, 4'b0111);
    check("mc_offset_cleared", led7seg, 7'h01);
    cyc(6);
    check("mc_step", step_pulse, 1'b1);
`endif

    cyc(3);
    #2 rst_n = 1'b0;
    #1;
    check("ar_trans", trans, 4'hF);
    check("ar_led", led7seg, 7'h7F);
    check("ar_step", step_pulse, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);
    check("ar_rel_trans", trans, 4'b0111);
    check("ar_rel_led", led7seg, 7'h7F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
